// File: rtl/wb_initiator_pkg.sv
// wb_initiator_pkg: shared Wishbone widths, FSM states and response status codes
package wb_initiator_pkg;
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = WB_DW / 8;
  localparam int TMR_W = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_GAP, ST_RESP} state_t;
  typedef enum logic [1:0] {WB_ST_OK, WB_ST_ERR, WB_ST_TIMEOUT, WB_ST_RETRY} status_t;
  function automatic status_t term_status(input logic err, input logic ack, input logic rty);
    return err ? WB_ST_ERR : ack ? WB_ST_OK : rty ? WB_ST_RETRY : WB_ST_TIMEOUT;
  endfunction
endpackage

// File: rtl/wb_cycle_timer.sv
// wb_cycle_timer: loadable down-counter with zero flag, shared by bus timeout and retry gap
module wb_cycle_timer
  import wb_initiator_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             zero
);
  logic [TMR_W-1:0] cnt;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - TMR_W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/wb_initiator.sv
// wb_initiator: Wishbone classic initiator with retry/timeout; WB_INITIATOR_STATS_EN adds OK/fail counters
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRIES    = 3,
  parameter int RETRY_GAP      = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [WB_AW-1:0] req_adr_i,
  input  logic [WB_DW-1:0] req_dat_i,
  input  logic [WB_SW-1:0] req_sel_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WB_DW-1:0] rsp_dat_o,
  output logic [1:0]       rsp_status_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [WB_AW-1:0] adr_o,
  output logic [WB_SW-1:0] sel_o,
  output logic [WB_DW-1:0] dat_o,
  input  logic [WB_DW-1:0] dat_i,
  input  logic             ack_i,
  input  logic             err_i,
  input  logic             rty_i
`ifdef WB_INITIATOR_STATS_EN
  ,
  output logic [15:0]      stat_ok_o,
  output logic [15:0]      stat_fail_o
`endif
);
  state_t state, state_d;
  logic [TMR_W-1:0] retry_cnt, load_val;
  logic load, tmr_zero, can_retry;
  assign req_ready_o = state == ST_IDLE;
  assign can_retry = retry_cnt < TMR_W'(MAX_RETRIES);
  wb_cycle_timer u_timer (.clk_i, .rst_ni, .load, .load_val, .zero(tmr_zero));
  // timer runs TIMEOUT_CYCLES-1..0 across a strobe, or RETRY_GAP-1..0 across a gap
  always_comb begin
    state_d = state;
    load = 1'b0;
    load_val = TMR_W'(TIMEOUT_CYCLES - 1);
    case (state)
      ST_IDLE: if (req_valid_i) begin
        state_d = ST_BUS;
        load = 1'b1;
      end
      ST_BUS: if (err_i || ack_i || (rty_i && !can_retry) || (!rty_i && tmr_zero)) state_d = ST_RESP;
      else if (rty_i) begin
        state_d = ST_GAP;
        load = 1'b1;
        load_val = TMR_W'(RETRY_GAP - 1);
      end
      ST_GAP: if (tmr_zero) begin
        state_d = ST_BUS;
        load = 1'b1;
      end
      default: if (rsp_ready_i) state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= ST_IDLE;
    else state <= state_d;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cyc_o <= 1'b0;
      stb_o <= 1'b0;
      we_o <= 1'b0;
      adr_o <= '0;
      sel_o <= '0;
      dat_o <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o <= '0;
      rsp_status_o <= '0;
      retry_cnt <= '0;
    end else begin
      cyc_o <= state_d == ST_BUS;
      stb_o <= state_d == ST_BUS;
      rsp_valid_o <= state_d == ST_RESP;
      if (req_valid_i && req_ready_o) begin
        we_o <= req_we_i;
        adr_o <= req_adr_i;
        sel_o <= req_sel_i;
        dat_o <= req_dat_i;
        retry_cnt <= '0;
      end
      if (state == ST_BUS && state_d == ST_GAP) retry_cnt <= retry_cnt + TMR_W'(1);
      if (state == ST_BUS && state_d == ST_RESP) begin
        rsp_status_o <= term_status(err_i, ack_i, rty_i);
        rsp_dat_o <= (ack_i && !err_i && !we_o) ? dat_i : '0;
      end
    end
`ifdef WB_INITIATOR_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      stat_ok_o <= '0;
      stat_fail_o <= '0;
    end else if (rsp_valid_o && rsp_ready_i) begin
      if (rsp_status_o == WB_ST_OK && stat_ok_o != '1) stat_ok_o <= stat_ok_o + 16'd1;
      if (rsp_status_o != WB_ST_OK && stat_fail_o != '1) stat_fail_o <= stat_fail_o + 16'd1;
    end
`endif
endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: randomized scripted responder with queue scoreboard against a transaction-level model
module tb_wb_initiator;
  localparam int T = 8, MR = 3, GAP = 2;
  localparam int K_NONE = 0, K_ACK = 1, K_ERR = 2, K_RTY = 3, K_EA = 4, K_AR = 5;
  typedef struct {
    logic [1:0]  st;
    logic [31:0] dat;
    int          stb;
    int          strobes;
    int          lat;
    int          wl;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [3:0]  sel;
  } exp_t;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, req_we = 0;
  logic [31:0] req_adr = 0, req_dat = 0;
  logic [3:0] req_sel = 0;
  logic rsp_valid, rsp_ready = 0;
  logic [31:0] rsp_dat;
  logic [1:0] rsp_status;
  logic cyc, stb, we;
  logic [31:0] adr, wdat, wb_rdat;
  logic [3:0] sel;
  logic ack, err, rty, hit;
  int kinds[8], waits[8], n_att = 0, att_idx, wcnt, cur_kind, cur_hold = 0, hcnt = 0;
  logic [31:0] rdata = 0;
  exp_t exp_q[$];
  int checks = 0, errors = 0;
  int cyc_n, acc_cyc, stb_c, strb_c, wl_c, lat_c;
  bit prev_stb, seen, attr_bad, stab_bad;
  logic [31:0] h_dat;
  logic [1:0] h_st;
  exp_t e_mon;

  always #5 clk = ~clk;

  wb_initiator #(.TIMEOUT_CYCLES(T), .MAX_RETRIES(MR), .RETRY_GAP(GAP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_adr_i(req_adr), .req_dat_i(req_dat), .req_sel_i(req_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_status_o(rsp_status),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .sel_o(sel), .dat_o(wdat), .dat_i(wb_rdat),
    .ack_i(ack), .err_i(err), .rty_i(rty)
  );

  // scripted responder: attempt i terminates combinationally after waits[i] extra strobe cycles
  always_comb begin
    cur_kind = (att_idx < n_att) ? kinds[att_idx & 7] : K_NONE;
    hit = stb && cur_kind != K_NONE && wcnt == waits[att_idx & 7];
    ack = hit && (cur_kind == K_ACK || cur_kind == K_EA || cur_kind == K_AR);
    err = hit && (cur_kind == K_ERR || cur_kind == K_EA);
    rty = hit && (cur_kind == K_RTY || cur_kind == K_AR);
    wb_rdat = ack ? rdata : 32'hDEAD_BEEF;
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      att_idx <= 0;
      wcnt <= 0;
    end else if (req_valid && req_ready) begin
      att_idx <= 0;
      wcnt <= 0;
    end else if (stb) begin
      if (hit || wcnt == T - 1) begin
        att_idx <= att_idx + 1;
        wcnt <= 0;
      end else wcnt <= wcnt + 1;
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, want);
    end
  endtask

  task automatic abort(input string name);
    errors++;
    $display("FAIL %s bound expired", name);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "stopped");
  endtask

  task automatic sc(input int i, input int k, input int w);
    kinds[i] = k;
    waits[i] = w;
    n_att = i + 1;
  endtask

  // transaction-level outcome of the current script, from the termination rules
  function automatic exp_t model(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    int used;
    e = '{default: 0};
    e.we = w;
    e.adr = a;
    e.wd = d;
    e.sel = s;
    e.lat = 1;
    used = 0;
    for (int i = 0; i < 16; i++) begin
      int k = (i < n_att) ? kinds[i] : K_NONE;
      int wt = (i < n_att) ? waits[i] : 0;
      e.strobes++;
      if (k == K_NONE || wt >= T) begin
        e.stb += T;
        e.lat += T;
        e.st = 2;
        break;
      end
      e.stb += wt + 1;
      e.lat += wt + 1;
      if (k == K_ERR || k == K_EA) begin
        e.st = 1;
        break;
      end
      if (k == K_ACK || k == K_AR) begin
        e.st = 0;
        e.dat = w ? 32'h0 : rdata;
        e.wl = w ? 1 : 0;
        break;
      end
      if (used == MR) begin
        e.st = 3;
        break;
      end
      used++;
      e.lat += GAP;
    end
    return e;
  endfunction

  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int hold, input bit rst_mid);
    exp_t e;
    int g;
    e = model(w, a, d, s);
    cur_hold = hold;
    if (!rst_mid) exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1;
    req_we = w;
    req_adr = a;
    req_dat = d;
    req_sel = s;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!req_ready && g < 100);
    if (!req_ready) abort("accept");
    @(posedge clk);
    #1;
    req_valid = 0;
    if (rst_mid) begin
      repeat (3) @(negedge clk);
      chk("pre_rst_stb", stb, 1);
      #2 rst_n = 0;
      #1;
      chk("rst_cyc", cyc, 0);
      chk("rst_stb", stb, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_ready", req_ready, 1);
      @(negedge clk);
      rst_n = 1;
    end else begin
      g = 0;
      while (exp_q.size() != 0 && g < 500) begin
        @(negedge clk);
        g++;
      end
      if (exp_q.size() != 0) abort("response");
      @(posedge clk);
      #1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (!rsp_valid) begin
      rsp_ready = 0;
      hcnt = 0;
    end else begin
      rsp_ready = hcnt >= cur_hold;
      hcnt++;
    end
  end

  // monitor: measures each transaction on the bus and scores it at the response handshake
  initial begin
    cyc_n = 0;
    prev_stb = 0;
    seen = 0;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (!rst_n) begin
        prev_stb = 0;
        seen = 0;
        continue;
      end
      if (req_valid && req_ready) begin
        acc_cyc = cyc_n;
        stb_c = 0;
        strb_c = 0;
        wl_c = 0;
        attr_bad = 0;
        stab_bad = 0;
        seen = 0;
      end
      if (stb) begin
        stb_c++;
        if (!prev_stb) strb_c++;
        if (exp_q.size() > 0 && (adr != exp_q[0].adr || we != exp_q[0].we || wdat != exp_q[0].wd ||
            sel != exp_q[0].sel || !cyc)) attr_bad = 1;
        if (ack && !err && we) wl_c++;
      end
      prev_stb = stb;
      if (rsp_valid) begin
        if (req_ready) stab_bad = 1;
        if (!seen) begin
          seen = 1;
          lat_c = cyc_n - acc_cyc;
          h_dat = rsp_dat;
          h_st = rsp_status;
        end else if (rsp_dat != h_dat || rsp_status != h_st) stab_bad = 1;
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp status=%0d dat=%0h", rsp_status, rsp_dat);
          end else begin
            e_mon = exp_q.pop_front();
            chk("status", 32'(rsp_status), 32'(e_mon.st));
            chk("rsp_dat", rsp_dat, e_mon.dat);
            chk("stb_cycles", stb_c, e_mon.stb);
            chk("strobes", strb_c, e_mon.strobes);
            chk("latency", lat_c, e_mon.lat);
            chk("writes_landed", wl_c, e_mon.wl);
            chk("bus_attrs", 32'(attr_bad), 0);
            chk("rsp_stable", 32'(stab_bad), 0);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    abort("watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_cyc", cyc, 0);
    chk("reset_stb", stb, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_adr", adr, 0);
    rst_n = 1;
    rdata = 32'h0000_A55A;
    sc(0, K_ACK, 0);
    run_txn(0, 32'h10, 32'h0, 4'hF, 0, 0);
    sc(0, K_ACK, 3);
    run_txn(1, 32'h20, 32'hC3, 4'hF, 1, 0);
    rdata = 32'h1234_5678;
    sc(0, K_RTY, 0); sc(1, K_RTY, 0); sc(2, K_ACK, 0);
    run_txn(0, 32'h30, 32'h0, 4'h3, 0, 0);
    sc(0, K_RTY, 0); sc(1, K_RTY, 1); sc(2, K_RTY, 0); sc(3, K_RTY, 2); sc(4, K_ACK, 0);
    run_txn(1, 32'h34, 32'h55AA, 4'hC, 0, 0);
    n_att = 0;
    run_txn(0, 32'h50, 32'h0, 4'hF, 5, 0);
    sc(0, K_EA, 1);
    run_txn(0, 32'h60, 32'h0, 4'hF, 2, 0);
    sc(0, K_AR, 0);
    run_txn(1, 32'h64, 32'hBEEF, 4'h1, 0, 0);
    sc(0, K_ACK, T - 1);
    run_txn(0, 32'h70, 32'h0, 4'hF, 0, 0);
    sc(0, K_ACK, T);
    run_txn(0, 32'h74, 32'h0, 4'hF, 0, 0);
    for (int t = 0; t < 40; t++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++)
        sc(i, ($urandom_range(0, 9) == 0) ? K_NONE : $urandom_range(1, 5),
           ($urandom_range(0, 7) == 0) ? $urandom_range(T - 1, T + 1) : $urandom_range(0, 2));
      rdata = $urandom;
      run_txn(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3), 0);
    end
    n_att = 0;
    run_txn(1, 32'h80, 32'h1111, 4'hF, 0, 1);
    rdata = 32'hCAFE_0001;
    sc(0, K_ACK, 0);
    run_txn(0, 32'h84, 32'h0, 4'hF, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Wishbone classic initiator (bus master) for the SoC fabric; the counterpart of the existing register-mapped responders (gpio and similar).
- Accepts single 32-bit read/write requests on a valid/ready command port and runs one Wishbone cycle per request.
- Handles ack/err/rty terminations, bounded retry and a bus timeout, then returns data and status on a valid/ready response port.
- Sits between a CPU-side load/store unit or debug bridge and the shared Wishbone bus.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles stb_o stays high without ack/err/rty before TIMEOUT status; legal range 1..65535.
- MAX_RETRIES, 3: number of rty-triggered re-issues before RETRY status; 0 disables retry.
- RETRY_GAP, 2: idle cycles (cyc_o low) between rty and re-issue; minimum 1.

Ports:
- clk_i  in  1  system clock; all logic on rising edge
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&&ready
- req_we_i  in  1  1=write, 0=read
- req_adr_i  in  32  byte address
- req_dat_i  in  32  write data
- req_sel_i  in  4  byte selects
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&&ready
- rsp_dat_o  out  32  read data; 0 for writes or on failure
- rsp_status_o  out  2  0=OK, 1=ERR, 2=TIMEOUT, 3=RETRY (retries exhausted)
- cyc_o, stb_o, we_o  out  1 each  Wishbone strobes
- adr_o  out  32  Wishbone address
- sel_o  out  4  Wishbone byte selects
- dat_o  out  32  Wishbone write data
- dat_i  in  32  Wishbone read data; may be Z unless a responder is acking
- ack_i, err_i, rty_i  in  1 each  Wishbone terminations

Behaviour:
- Reset (async, rst_ni low): state IDLE; all outputs 0 except req_ready_o=1; counters cleared.
- Reset is honoured mid-cycle: cyc_o and stb_o drop immediately and any pending response is discarded.
- Outputs are registered, except req_ready_o, which is 1 exactly when state==IDLE.
- IDLE:
  - On req_valid_i, capture we/adr/dat/sel into adr_o/we_o/dat_o/sel_o.
  - Clear retry_cnt; go to BUS.
  - stb_o and cyc_o are high from the cycle after acceptance.
- BUS:
  - cyc_o=stb_o=1. Responders may terminate combinationally, so ack_i is sampled in the first stb cycle.
  - Termination priority when several are asserted: err_i > ack_i > rty_i.
  - ack_i: latch dat_i into rsp_dat_o if !we_o, else 0; status OK; go to RESP.
  - err_i: status ERR, rsp_dat_o=0; go to RESP.
  - rty_i with retry_cnt<MAX_RETRIES: retry_cnt++; go to GAP.
  - rty_i with retry_cnt==MAX_RETRIES: status RETRY; go to RESP.
  - No termination and tmo_cnt==TIMEOUT_CYCLES-1: status TIMEOUT; go to RESP.
  - tmo_cnt clears on entry to BUS and counts cycles spent in BUS.
  - On leaving BUS, cyc_o/stb_o go low on the next edge. Each accepted ack therefore produces exactly one single-cycle strobe with a combinational responder, so a write lands exactly once.
- GAP: cyc_o=stb_o=0 for RETRY_GAP cycles; adr/dat/sel/we held; then BUS.
- RESP:
  - rsp_valid_o=1; rsp_dat_o and rsp_status_o stable until rsp_ready_i.
  - On handshake, return to IDLE.
  - The next request cannot be accepted until the cycle after the response handshake.
- adr_o/dat_o/sel_o/we_o hold their last values outside BUS and are qualified by stb_o only.
- End-to-end latency with a zero-wait responder: request accept N, stb N+1, rsp_valid N+2.

Optional Feature:
- WB_INITIATOR_STATS_EN defined:
  - Adds outputs stat_ok_o[15:0] and stat_fail_o[15:0], both saturating counters.
  - stat_ok_o increments on each OK response handshake; stat_fail_o on each ERR/TIMEOUT/RETRY handshake.
  - Both clear on reset.
- Undefined: these ports and counters are absent.

Decomposition:
- Shared header wb_defs.vh (also used by responders):
  - status codes WB_ST_OK/ERR/TIMEOUT/RETRY;
  - FSM state encodings ST_IDLE/ST_BUS/ST_GAP/ST_RESP (2-bit);
  - WB data/address width constants.
- One natural sub-module, wb_cycle_timer: a loadable down-counter with a zero flag, shared by the timeout and retry-gap counting.

Test Plan:
- Read gpio-style zero-wait responder (ack same cycle) at 0x0000_0010 returning 0x0000_A55A -> stb_o high exactly 1 cycle; rsp_dat_o=0x0000_A55A, status 0; rsp_valid 2 cycles after accept.
- Write 0x0000_00C3, sel 0xF, with a 3-wait-state responder -> stb_o held 4 cycles; dat_o stable throughout; status 0; rsp_dat_o=0.
- Responder asserts rty_i twice then ack_i, MAX_RETRIES=3, RETRY_GAP=2 -> 3 bus strobes, each separated by 2 cyc_o-low cycles; status 0. With rty_i always asserted -> 4 strobes, then status 3.
- No responder, TIMEOUT_CYCLES=8 -> stb_o high 8 cycles, then status 2; hold rsp_ready_i low 5 cycles -> response stable and req_ready_o stays 0.
- err_i and ack_i asserted together -> status 1, rsp_dat_o=0. Then drive rst_ni low mid-BUS -> cyc_o/stb_o low asynchronously and rsp_valid_o=0.
